// File: rtl/fir_pkg.sv
// Shared constants, state encoding and mirror-index helper
// for the symmetric FIR coefficient loader.
package fir_pkg;

  localparam int TAPS = 33;
  localparam int UNIQ = (TAPS + 1) / 2;
  localparam int AW   = 6;
  localparam int DW   = 16;
  localparam int CW   = 5;

  localparam logic [1:0] p_Idle    = 2'd0;
  localparam logic [1:0] p_Collect = 2'd1;
  localparam logic [1:0] p_Write   = 2'd2;
  localparam logic [1:0] p_Done    = 2'd3;

  // Buffer slot feeding RAM address k (1..TAPS): taps mirror
  // around the centre, so k and TAPS+1-k share a slot.
  function automatic logic [CW-1:0] idx(input logic [AW-1:0] k);
    if (k <= AW'(UNIQ))
      return CW'(k - AW'(1));
    else
      return CW'(AW'(TAPS) - k);
  endfunction

endpackage

// File: rtl/fir_coeff_loader.sv
// Collects UNIQ coefficients over valid/ready, then writes the
// mirrored TAPS-entry table into the FIR coefficient RAM.
// Ports: iClk_12M/iRsn clock+async reset; iLoadStart/iAbort
// control; iCoeffValid/iCoeffData/oCoeffReady host stream;
// oCoeffiUpdateFlag/oCsnRam/oWrnRam/oAddrRam/oWrDtRam RAM port;
// oBusy/oDone status. All outputs registered.
module fir_coeff_loader
  import fir_pkg::*;
(
  input  logic          iClk_12M,
  input  logic          iRsn,
  input  logic          iLoadStart,
  input  logic          iAbort,
  input  logic          iCoeffValid,
  input  logic [DW-1:0] iCoeffData,
  output logic          oCoeffReady,
  output logic          oCoeffiUpdateFlag,
  output logic          oCsnRam,
  output logic          oWrnRam,
  output logic [AW-1:0] oAddrRam,
  output logic [DW-1:0] oWrDtRam,
  output logic          oBusy,
  output logic          oDone
);

  logic [1:0]    state;
  logic [1:0]    nxt;
  logic [CW-1:0] cnt;
  logic [DW-1:0] cbuf [UNIQ];

  logic          cap;
  logic          last_cap;

  logic          ready_d;
  logic          wr_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] data_d;
  logic          busy_d;
  logic          done_d;

  // oCoeffReady is high exactly while in p_Collect
  assign cap      = (state == p_Collect) && iCoeffValid;
  assign last_cap = cap && (cnt == CW'(UNIQ - 1));

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) state <= p_Idle;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      p_Idle: begin
        if (iLoadStart) nxt = p_Collect;
      end
      p_Collect: begin
        if (iAbort)        nxt = p_Idle;
        else if (last_cap) nxt = p_Write;
      end
      p_Write: begin
        if (iAbort)                        nxt = p_Idle;
        else if (oAddrRam == AW'(TAPS))    nxt = p_Done;
      end
      p_Done: begin
        nxt = p_Idle;
      end
      default: nxt = p_Idle;
    endcase
  end

  // Outputs are computed from the next state so that the
  // registered values line up with the state they describe.
  always_comb begin
    ready_d = (nxt == p_Collect);
    wr_d    = (nxt == p_Write);
    busy_d  = (nxt == p_Collect) || (nxt == p_Write);
    done_d  = (nxt == p_Done);
    addr_d  = '0;
    data_d  = '0;
    if (wr_d) begin
      addr_d = (state == p_Write) ? oAddrRam + AW'(1) : AW'(1);
      data_d = cbuf[idx(addr_d)];
    end
  end

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      oCoeffReady       <= 1'b0;
      oCoeffiUpdateFlag <= 1'b0;
      oCsnRam           <= 1'b1;
      oWrnRam           <= 1'b1;
      oAddrRam          <= '0;
      oWrDtRam          <= '0;
      oBusy             <= 1'b0;
      oDone             <= 1'b0;
    end else begin
      oCoeffReady       <= ready_d;
      oCoeffiUpdateFlag <= wr_d;
      oCsnRam           <= !wr_d;
      oWrnRam           <= !wr_d;
      oAddrRam          <= addr_d;
      oWrDtRam          <= data_d;
      oBusy             <= busy_d;
      oDone             <= done_d;
    end
  end

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn)
      cnt <= '0;
    else if ((state == p_Idle) && iLoadStart)
      cnt <= '0;
    else if (cap)
      cnt <= cnt + CW'(1);
  end

  // Buffer holds no reset: contents are always rewritten
  // before they are read.
  always_ff @(posedge iClk_12M) begin
    if (cap) cbuf[cnt] <= iCoeffData;
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Randomised self-checking bench for fir_coeff_loader with a
// palindrome reference model of the RAM write sequence.
module tb_fir_coeff_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] data = '0;
  logic        ready;
  logic        flag;
  logic        csn;
  logic        wrn;
  logic [5:0]  addr;
  logic [15:0] wdat;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;

  logic [5:0]  w_addr[$];
  logic [15:0] w_data[$];
  int          w_cyc[$];
  int          done_cyc[$];
  int          ctl_bad = 0;
  logic [10:0] snap;
  logic [15:0] exp_q[$];
  logic [15:0] c[17];

  fir_coeff_loader dut (
    .iClk_12M(clk),
    .iRsn(rst_n),
    .iLoadStart(start),
    .iAbort(abort),
    .iCoeffValid(valid),
    .iCoeffData(data),
    .oCoeffReady(ready),
    .oCoeffiUpdateFlag(flag),
    .oCsnRam(csn),
    .oWrnRam(wrn),
    .oAddrRam(addr),
    .oWrDtRam(wdat),
    .oBusy(busy),
    .oDone(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (!csn) begin
        w_addr.push_back(addr);
        w_data.push_back(wdat);
        w_cyc.push_back(cyc);
        if (wrn !== 1'b0 || flag !== 1'b1) ctl_bad++;
      end else if (wrn !== 1'b1 || flag !== 1'b0) begin
        ctl_bad++;
      end
      if (done) done_cyc.push_back(cyc);
    end
  end

  // Written table is the unique list followed by its mirror,
  // centre tap not repeated.
  task automatic model();
    exp_q.delete();
    for (int i = 0; i < 17; i++) exp_q.push_back(c[i]);
    for (int i = 15; i >= 0; i--) exp_q.push_back(c[i]);
  endtask

  task automatic clear_obs();
    w_addr.delete();
    w_data.delete();
    w_cyc.delete();
    done_cyc.delete();
    ctl_bad = 0;
    snap = '1;
  endtask

  task automatic rand_c();
    for (int i = 0; i < 17; i++) c[i] = 16'($urandom);
  endtask

  // Drives one load; optionally aborts or re-pulses start when
  // the write reaches a given address.
  task automatic load(input int gap, input int abort_k,
                      input int start_k);
    logic ab;
    clear_obs();
    @(negedge clk);
    t0 = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 17; n++) begin
      valid = 1'b1;
      data = c[n];
      @(negedge clk);
      valid = 1'b0;
      data = 16'($urandom);
      if (n < 16) repeat (gap) @(negedge clk);
    end
    for (int i = 0; i < 45; i++) begin
      ab = !csn && (int'(addr) == abort_k);
      abort = ab;
      start = !csn && (int'(addr) == start_k);
      @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
      if (ab) snap = {flag, csn, wrn, addr, busy, done};
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ready, flag, csn, wrn, addr, wdat, busy, done} !==
        {4'b0011, 6'd0, 16'd0, 2'b00}) begin
      errors++;
      $display("FAIL reset_vals got %b", {ready, flag, csn, wrn,
               addr, wdat, busy, done});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle_ignore();
    clear_obs();
    for (int i = 0; i < 6; i++) begin
      valid = i[0];
      data = 16'($urandom);
      @(negedge clk);
      checks++;
      if (ready !== 1'b0 || busy !== 1'b0 || csn !== 1'b1) begin
        errors++;
        $display("FAIL idle_ignore r=%b b=%b csn=%b want 0 0 1",
                 ready, busy, csn);
      end
    end
    valid = 1'b0;
    checks++;
    if (w_addr.size() != 0 || done_cyc.size() != 0) begin
      errors++;
      $display("FAIL idle_noram writes=%0d dones=%0d want 0 0",
               w_addr.size(), done_cyc.size());
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 17; i++) c[i] = 16'(i + 1);
    model();
    load(0, 0, 0);
    checks++;
    if (w_addr.size() != 33 || ctl_bad != 0) begin
      errors++;
      $display("FAIL b2b_count writes=%0d ctlbad=%0d want 33 0",
               w_addr.size(), ctl_bad);
    end
    for (int i = 0; i < 33; i++) begin
      checks++;
      if (w_addr[i] !== 6'(i + 1) || w_data[i] !== exp_q[i] ||
          w_cyc[i] !== t0 + 18 + i) begin
        errors++;
        $display("FAIL b2b_wr%0d a=%0d d=%h c=%0d want %0d %h %0d",
                 i, w_addr[i], w_data[i], w_cyc[i] - t0,
                 i + 1, exp_q[i], 18 + i);
      end
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] !== t0 + 51) begin
      errors++;
      $display("FAIL b2b_done n=%0d cyc=%0d want 1 51",
               done_cyc.size(), done_cyc[0] - t0);
    end
  endtask

  task automatic test_gaps();
    rand_c();
    model();
    load(3, 0, 0);
    checks++;
    if (w_addr.size() != 33 || ctl_bad != 0) begin
      errors++;
      $display("FAIL gap_count writes=%0d ctlbad=%0d want 33 0",
               w_addr.size(), ctl_bad);
    end
    for (int i = 0; i < 33; i++) begin
      checks++;
      if (w_addr[i] !== 6'(i + 1) || w_data[i] !== exp_q[i] ||
          w_cyc[i] !== t0 + 66 + i) begin
        errors++;
        $display("FAIL gap_wr%0d a=%0d d=%h c=%0d want %0d %h %0d",
                 i, w_addr[i], w_data[i], w_cyc[i] - t0,
                 i + 1, exp_q[i], 66 + i);
      end
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] !== t0 + 99) begin
      errors++;
      $display("FAIL gap_done n=%0d cyc=%0d want 1 99",
               done_cyc.size(), done_cyc[0] - t0);
    end
  endtask

  task automatic test_abort();
    rand_c();
    load(0, 10, 0);
    checks++;
    if (w_addr.size() != 10 || done_cyc.size() != 0) begin
      errors++;
      $display("FAIL abort_stop writes=%0d dones=%0d want 10 0",
               w_addr.size(), done_cyc.size());
    end
    checks++;
    if (snap !== {3'b011, 6'd0, 2'b00}) begin
      errors++;
      $display("FAIL abort_idle got %b want 01100000000", snap);
    end
    rand_c();
    model();
    load(1, 0, 0);
    checks++;
    if (w_addr.size() != 33 || ctl_bad != 0) begin
      errors++;
      $display("FAIL reload_count writes=%0d ctlbad=%0d want 33 0",
               w_addr.size(), ctl_bad);
    end
    for (int i = 0; i < 33; i++) begin
      checks++;
      if (w_addr[i] !== 6'(i + 1) || w_data[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL reload_wr%0d a=%0d d=%h want %0d %h",
                 i, w_addr[i], w_data[i], i + 1, exp_q[i]);
      end
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] !== t0 + 67) begin
      errors++;
      $display("FAIL reload_done n=%0d cyc=%0d want 1 67",
               done_cyc.size(), done_cyc[0] - t0);
    end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 8; n++) begin
      valid = 1'b1;
      data = 16'($urandom);
      @(negedge clk);
    end
    valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ready, flag, csn, wrn, addr, wdat, busy, done} !==
        {4'b0011, 6'd0, 16'd0, 2'b00}) begin
      errors++;
      $display("FAIL rstmid_vals got %b", {ready, flag, csn, wrn,
               addr, wdat, busy, done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      valid = 1'b1;
      data = 16'($urandom);
      @(negedge clk);
    end
    valid = 1'b0;
    checks++;
    if (ready !== 1'b0 || busy !== 1'b0 || w_addr.size() != 0 ||
        done_cyc.size() != 0) begin
      errors++;
      $display("FAIL rstmid_after r=%b b=%b wr=%0d dn=%0d want 0",
               ready, busy, w_addr.size(), done_cyc.size());
    end
  endtask

  task automatic test_start_while_busy();
    rand_c();
    model();
    load(0, 0, 5);
    checks++;
    if (w_addr.size() != 33 || ctl_bad != 0) begin
      errors++;
      $display("FAIL sbusy_count writes=%0d ctlbad=%0d want 33 0",
               w_addr.size(), ctl_bad);
    end
    for (int i = 0; i < 33; i++) begin
      checks++;
      if (w_addr[i] !== 6'(i + 1) || w_data[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL sbusy_wr%0d a=%0d d=%h want %0d %h",
                 i, w_addr[i], w_data[i], i + 1, exp_q[i]);
      end
    end
    checks++;
    if (done_cyc.size() != 1 || busy !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL sbusy_once dones=%0d busy=%b ready=%b want 1 0 0",
               done_cyc.size(), busy, ready);
    end
  endtask

  task automatic test_signed();
    rand_c();
    c[0] = 16'h8000;
    c[16] = 16'h7FFF;
    model();
    load(0, 0, 0);
    checks++;
    if (w_addr.size() != 33 || ctl_bad != 0) begin
      errors++;
      $display("FAIL signed_count writes=%0d ctlbad=%0d want 33 0",
               w_addr.size(), ctl_bad);
    end
    for (int i = 0; i < 33; i++) begin
      checks++;
      if (w_addr[i] !== 6'(i + 1) || w_data[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL signed_wr%0d a=%0d d=%h want %0d %h",
                 i, w_addr[i], w_data[i], i + 1, exp_q[i]);
      end
    end
    checks++;
    if (w_data[0] !== 16'h8000 || w_data[16] !== 16'h7FFF ||
        w_data[32] !== 16'h8000) begin
      errors++;
      $display("FAIL signed_ends got %h %h %h want 8000 7fff 8000",
               w_data[0], w_data[16], w_data[32]);
    end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_back_to_back();
    test_gaps();
    test_abort();
    test_reset_mid();
    test_start_while_busy();
    test_signed();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
